// File: rtl/sample_dispatch.sv
// sample_dispatch: input FIFO feeding the DSP pipeline sequencer with a
// valid/ready-drop/ready-rise handshake, a dry bypass path, a per-sample hang
// timeout and sticky overrun/timeout flags.
module sample_dispatch #(
  parameter int unsigned data_width     = 16,
  parameter int unsigned fifo_depth     = 4,
  parameter int unsigned timeout_cycles = 4096
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [data_width-1:0]         adc_sample,
  input  logic                          adc_valid,
  output logic [data_width-1:0]         pipe_sample,
  output logic                          pipe_valid,
  input  logic                          pipe_ready,
  input  logic [data_width-1:0]         pipe_out_sample,
  output logic [data_width-1:0]         dac_sample,
  output logic                          dac_valid,
  output logic [$clog2(fifo_depth):0]   fifo_level,
  output logic                          busy,
  input  logic                          clear_flags,
  output logic                          overrun,
  output logic                          timeout
);

  localparam int unsigned PTR_W = $clog2(fifo_depth);
  localparam int unsigned LVL_W = PTR_W + 1;
  // One spare bit so the counter can step past the limit after a late
  // WAIT_DROP -> WAIT_DONE move and still trip the timeout next cycle.
  localparam int unsigned CNT_W = $clog2(timeout_cycles) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(fifo_depth);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_DROP = 2'b01,
    WAIT_DONE = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [data_width-1:0] mem_q [fifo_depth];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [data_width-1:0] pipe_sample_q, pipe_sample_d;
  logic                  pipe_valid_q, pipe_valid_d;
  logic [data_width-1:0] dac_sample_q, dac_sample_d;
  logic                  dac_valid_q, dac_valid_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;
  logic                  pop, push, to_set, ovr_set;

  // Dispatch FSM: pops the head in IDLE, tracks ready drop/rise, times out.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pipe_sample_d = pipe_sample_q;
    pipe_valid_d  = 1'b0;
    dac_sample_d  = dac_sample_q;
    dac_valid_d   = 1'b0;
    pop           = 1'b0;
    to_set        = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          if (!enable) begin
            pop          = 1'b1;
            dac_sample_d = mem_q[rd_ptr_q];
            dac_valid_d  = 1'b1;
          end else if (pipe_ready) begin
            pop           = 1'b1;
            pipe_sample_d = mem_q[rd_ptr_q];
            pipe_valid_d  = 1'b1;
            cnt_d         = '0;
            state_d       = WAIT_DROP;
          end
        end
      end
      WAIT_DROP, WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_q == WAIT_DROP && !pipe_ready) begin
          state_d = WAIT_DONE;
        end else if (state_q == WAIT_DONE && pipe_ready) begin
          dac_sample_d = pipe_out_sample;
          dac_valid_d  = 1'b1;
          state_d      = IDLE;
        end else if (cnt_q >= CNT_LAST) begin
          to_set       = 1'b1;
          dac_sample_d = pipe_sample_q;
          dac_valid_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        to_set  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping, busy and sticky flags (a set beats a clear).
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    push     = adc_valid && ((level_q != FULL_LVL) || pop);
    ovr_set  = adc_valid && (level_q == FULL_LVL) && !pop;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    busy_d    = (state_d != IDLE);
    overrun_d = ovr_set | (overrun_q & ~clear_flags);
    timeout_d = to_set  | (timeout_q & ~clear_flags);
  end

  // FIFO storage; contents are don't-care after reset since level is 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= adc_sample;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      level_q       <= '0;
      cnt_q         <= '0;
      pipe_sample_q <= '0;
      pipe_valid_q  <= 1'b0;
      dac_sample_q  <= '0;
      dac_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      level_q       <= level_d;
      cnt_q         <= cnt_d;
      pipe_sample_q <= pipe_sample_d;
      pipe_valid_q  <= pipe_valid_d;
      dac_sample_q  <= dac_sample_d;
      dac_valid_q   <= dac_valid_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  assign pipe_sample = pipe_sample_q;
  assign pipe_valid  = pipe_valid_q;
  assign dac_sample  = dac_sample_q;
  assign dac_valid   = dac_valid_q;
  assign fifo_level  = level_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_sample_dispatch.sv
// Bench for sample_dispatch: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based behavioural model.
module tb_sample_dispatch;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [DW-1:0] adc_sample;
  logic          adc_valid;
  logic [DW-1:0] pipe_sample;
  logic          pipe_valid;
  logic          pipe_ready;
  logic [DW-1:0] pipe_out_sample;
  logic [DW-1:0] dac_sample;
  logic          dac_valid;
  logic [2:0]    fifo_level;
  logic          busy;
  logic          clear_flags;
  logic          overrun;
  logic          timeout;

  sample_dispatch #(
    .data_width    (DW),
    .fifo_depth    (DEPTH),
    .timeout_cycles(TO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .adc_sample     (adc_sample),
    .adc_valid      (adc_valid),
    .pipe_sample    (pipe_sample),
    .pipe_valid     (pipe_valid),
    .pipe_ready     (pipe_ready),
    .pipe_out_sample(pipe_out_sample),
    .dac_sample     (dac_sample),
    .dac_valid      (dac_valid),
    .fifo_level     (fifo_level),
    .busy           (busy),
    .clear_flags    (clear_flags),
    .overrun        (overrun),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: sample queue, pipeline phase and per-sample wait count.
  logic [DW-1:0] mq[$];
  int            m_phase;  // 0 idle, 1 waiting for ready to drop, 2 waiting for ready to rise
  int            m_cnt;
  logic [DW-1:0] m_psamp, m_dsamp;
  bit            m_pv, m_dv, m_ovr, m_to;

  function automatic void model_reset();
    mq.delete();
    m_phase = 0; m_cnt = 0;
    m_psamp = '0; m_dsamp = '0;
    m_pv = 0; m_dv = 0; m_ovr = 0; m_to = 0;
  endfunction

  function automatic void model_step();
    bit full, popped, set_ovr, set_to;
    logic [DW-1:0] head;
    full = (mq.size() == DEPTH);
    popped = 0; set_ovr = 0; set_to = 0;
    m_pv = 0; m_dv = 0;
    if (m_phase == 0) begin
      if (mq.size() > 0 && (!enable || pipe_ready)) begin
        head = mq.pop_front();
        popped = 1;
        if (!enable) begin
          m_dsamp = head; m_dv = 1;
        end else begin
          m_psamp = head; m_pv = 1; m_cnt = 0; m_phase = 1;
        end
      end
    end else begin
      if (m_phase == 1 && !pipe_ready) m_phase = 2;
      else if (m_phase == 2 && pipe_ready) begin
        m_dsamp = pipe_out_sample; m_dv = 1; m_phase = 0;
      end else if (m_cnt >= TO - 1) begin
        set_to = 1; m_dsamp = m_psamp; m_dv = 1; m_phase = 0;
      end
      m_cnt++;
    end
    if (adc_valid) begin
      if (full && !popped) set_ovr = 1;
      else mq.push_back(adc_sample);
    end
    m_ovr = set_ovr || (m_ovr && !clear_flags);
    m_to  = set_to  || (m_to  && !clear_flags);
  endfunction

  task automatic compare_outputs();
    check_eq("pipe_valid",  32'(pipe_valid),  32'(m_pv));
    check_eq("pipe_sample", 32'(pipe_sample), 32'(m_psamp));
    check_eq("dac_valid",   32'(dac_valid),   32'(m_dv));
    check_eq("dac_sample",  32'(dac_sample),  32'(m_dsamp));
    check_eq("fifo_level",  32'(fifo_level),  32'(mq.size()));
    check_eq("busy",        32'(busy),        32'(m_phase != 0));
    check_eq("overrun",     32'(overrun),     32'(m_ovr));
    check_eq("timeout",     32'(timeout),     32'(m_to));
  endtask

  int            n_pv, n_dv;
  logic [DW-1:0] pv_log[$];
  logic [DW-1:0] dv_log[$];

  task automatic clear_logs();
    n_pv = 0; n_dv = 0;
    pv_log.delete(); dv_log.delete();
  endtask

  // One clock: advance model with current inputs, then sample DUT #1 after the edge.
  task automatic step();
    if (!reset_n) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    compare_outputs();
    if (pipe_valid) begin n_pv++; pv_log.push_back(pipe_sample); end
    if (dac_valid)  begin n_dv++; dv_log.push_back(dac_sample);  end
  endtask

  // Pipeline stand-in: drops ready after a dispatch, holds low, then rises.
  int pl_mode = 0, pl_wait = 0, pl_low = 0;

  task automatic drive_pipe();
    if (m_pv) begin
      if ($urandom_range(0, 7) == 0) pl_mode = 0;
      else begin
        pl_mode = 1;
        pl_wait = $urandom_range(0, 2);
        pl_low  = ($urandom_range(0, 5) == 0) ? 20 : $urandom_range(1, 10);
      end
    end
    pipe_out_sample = DW'($urandom);
    case (pl_mode)
      1: if (pl_wait == 0) begin pipe_ready = 0; pl_mode = 2; end
         else begin pipe_ready = 1; pl_wait--; end
      2: if (pl_low == 0) begin pipe_ready = 1; pl_mode = 0; end
         else begin pipe_ready = 0; pl_low--; end
      default: pipe_ready = 1;
    endcase
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      drive_pipe();
      step();
    end
  endtask

  function automatic logic [31:0] log_at(input int which, input int idx);
    if (which == 0) return (idx < pv_log.size()) ? 32'(pv_log[idx]) : 'x;
    return (idx < dv_log.size()) ? 32'(dv_log[idx]) : 'x;
  endfunction

  initial begin
    int dv_at;
    reset_n = 0; enable = 0; adc_valid = 0; adc_sample = '0;
    pipe_ready = 1; pipe_out_sample = '0; clear_flags = 0;
    model_reset();
    clear_logs();

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      enable = 1'($urandom); adc_valid = 1'($urandom); adc_sample = DW'($urandom);
      pipe_ready = 1'($urandom); pipe_out_sample = DW'($urandom); clear_flags = 1'($urandom);
      step();
    end
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_busy",  32'(busy),       32'd0);
    enable = 1; adc_valid = 0; pipe_ready = 1; clear_flags = 0;
    reset_n = 1;
    step();

    // Normal path
    clear_logs();
    adc_sample = 16'h1234; adc_valid = 1; step(); adc_valid = 0;
    for (int i = 0; i < 5 && n_pv == 0; i++) step();
    pipe_ready = 0;
    repeat (10) step();
    pipe_ready = 1; pipe_out_sample = 16'h0ABC;
    for (int i = 0; i < 4; i++) step();
    check_eq("norm_pv_count", 32'(n_pv), 32'd1);
    check_eq("norm_pv_data",  log_at(0, 0), 32'h1234);
    check_eq("norm_dv_count", 32'(n_dv), 32'd1);
    check_eq("norm_dv_data",  log_at(1, 0), 32'h0ABC);
    check_eq("norm_busy",     32'(busy), 32'd0);

    // Burst and overrun
    clear_logs();
    pipe_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      adc_sample = DW'(i); adc_valid = 1; step();
    end
    adc_valid = 0; step();
    check_eq("burst_level",   32'(fifo_level), 32'd4);
    check_eq("burst_overrun", 32'(overrun),    32'd1);
    pl_mode = 0;
    drain(200);
    check_eq("burst_pv_count", 32'(n_pv), 32'd4);
    for (int i = 0; i < 4; i++) check_eq("burst_order", log_at(0, i), 32'(i + 1));
    clear_flags = 1; step(); clear_flags = 0;
    check_eq("clear_overrun", 32'(overrun), 32'd0);

    // Full FIFO with a pop on the same edge as a push
    clear_logs();
    pl_mode = 0; pipe_ready = 0;
    for (int i = 0; i < 4; i++) begin
      adc_sample = DW'(16'h10 + i); adc_valid = 1; step();
    end
    pipe_ready = 1; adc_sample = 16'h0099; adc_valid = 1; step(); adc_valid = 0;
    check_eq("fullpop_overrun", 32'(overrun),    32'd0);
    check_eq("fullpop_level",   32'(fifo_level), 32'd4);
    drain(200);
    check_eq("fullpop_pv_count", 32'(n_pv), 32'd5);
    for (int i = 0; i < 4; i++) check_eq("fullpop_order", log_at(0, i), 32'(16'h10 + i));
    check_eq("fullpop_last", log_at(0, 4), 32'h0099);

    // Dry bypass
    clear_logs();
    pl_mode = 0; pipe_ready = 1; enable = 0;
    adc_sample = 16'hFFFB; adc_valid = 1; step(); adc_valid = 0;
    check_eq("byp_early_dv", 32'(dac_valid), 32'd0);
    step();
    check_eq("byp_dv",   32'(dac_valid),  32'd1);
    check_eq("byp_data", 32'(dac_sample), 32'hFFFB);
    step(); step();
    check_eq("byp_no_pv", 32'(n_pv), 32'd0);
    check_eq("byp_dv_count", 32'(n_dv), 32'd1);

    // Timeout with ready stuck high
    enable = 1; pipe_ready = 1;
    clear_flags = 1; step(); clear_flags = 0;
    check_eq("to_cleared", 32'(timeout), 32'd0);
    clear_logs();
    adc_sample = 16'h0042; adc_valid = 1; step(); adc_valid = 0;
    step();
    check_eq("to_dispatch", 32'(pipe_valid), 32'd1);
    dv_at = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (dac_valid) begin dv_at = i; break; end
    end
    check_eq("to_latency", 32'(dv_at), 32'd16);
    check_eq("to_data",    32'(dac_sample), 32'h0042);
    check_eq("to_flag",    32'(timeout), 32'd1);
    check_eq("to_busy",    32'(busy), 32'd0);

    // Reset in the middle of a sample
    clear_flags = 1; step(); clear_flags = 0;
    adc_sample = 16'h0055; adc_valid = 1; step();
    adc_sample = 16'h0056; step(); adc_valid = 0;
    pipe_ready = 0; step(); step();
    #2 reset_n = 0;
    #1;
    model_reset();
    check_eq("midrst_busy",  32'(busy),        32'd0);
    check_eq("midrst_level", 32'(fifo_level),  32'd0);
    check_eq("midrst_psamp", 32'(pipe_sample), 32'd0);
    check_eq("midrst_flags", 32'({overrun, timeout, dac_valid, pipe_valid}), 32'd0);
    step();
    reset_n = 1; pipe_ready = 1; pl_mode = 0;
    clear_logs();
    for (int i = 0; i < 4; i++) step();
    check_eq("midrst_no_dv", 32'(n_dv), 32'd0);

    // Randomized traffic
    begin
      int rate;
      rate = 2;
      for (int i = 0; i < 3000; i++) begin
        if (i % 200 == 0) rate = $urandom_range(1, 5);
        adc_valid   = ($urandom_range(0, rate) == 0);
        adc_sample  = DW'($urandom);
        if ($urandom_range(0, 99) == 0) enable = ~enable;
        clear_flags = ($urandom_range(0, 49) == 0);
        drive_pipe();
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sample_dispatch.md
# sample_dispatch

Upstream feeder for the DSP pipeline sequencer. Buffers incoming ADC-rate samples in a small FIFO and hands them one at a time to the pipeline with a single-cycle valid pulse. It tracks the pipeline's ready drop/rise handshake, captures the processed sample and emits it towards the DAC. It also provides a dry-bypass path, a hang timeout, and sticky overrun/timeout flags.

## Interface
- data_width, 16, sample width (signed two's complement)
- fifo_depth, 4, input FIFO entries; power of two, ≥2
- timeout_cycles, 4096, max cycles spent waiting on the pipeline per sample; ≥4

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = route samples through pipeline; 0 = dry bypass
- adc_sample  in  data_width  incoming sample
- adc_valid  in  1  single-cycle strobe qualifying adc_sample
- pipe_sample  out  data_width  sample presented to pipeline
- pipe_valid  out  1  single-cycle dispatch strobe to pipeline
- pipe_ready  in  1  pipeline ready
- pipe_out_sample  in  data_width  pipeline result; meaningful while pipe_ready=1
- dac_sample  out  data_width  processed (or dry) sample
- dac_valid  out  1  single-cycle strobe qualifying dac_sample
- fifo_level  out  $clog2(fifo_depth)+1  current FIFO occupancy
- busy  out  1  high in any state other than IDLE
- clear_flags  in  1  synchronous clear of sticky flags
- overrun  out  1  sticky: a sample was dropped on a full FIFO
- timeout  out  1  sticky: the pipeline failed to complete within timeout_cycles

## Operation
- Reset (reset_n=0, asynchronous): FIFO empty, state IDLE, timeout counter 0. Every output is 0: pipe_sample, pipe_valid, dac_sample, dac_valid, fifo_level, busy, overrun, timeout.
- FIFO push: on each edge where adc_valid=1.
  - If full and no pop on the same edge: sample dropped, overrun←1, level unchanged.
  - If full and a pop occurs on the same edge: push accepted, level stays at fifo_depth.
  - Read and write pointers wrap modulo fifo_depth.
- State machine:
  - IDLE, FIFO non-empty, enable=0: pop the head. dac_sample←head, dac_valid←1. Stay in IDLE.
  - IDLE, FIFO non-empty, enable=1, pipe_ready=1: pop the head. pipe_sample←head, pipe_valid←1, timeout counter←0. Go to WAIT_DROP.
  - IDLE, FIFO non-empty, enable=1, pipe_ready=0: hold. Nothing is popped.
  - WAIT_DROP: when pipe_ready=0, go to WAIT_DONE.
  - WAIT_DONE: when pipe_ready=1, dac_sample←pipe_out_sample, dac_valid←1. Go to IDLE.
  - Timeout: in WAIT_DROP or WAIT_DONE, the counter increments every cycle. When it reaches timeout_cycles−1 with no transition: timeout←1, dac_sample←pipe_sample (dry fallback), dac_valid←1, go to IDLE.
- pipe_sample holds its value from dispatch until the next dispatch.
- enable is sampled only in IDLE. Changing it mid-sample does not abort the sample.
- pipe_valid and dac_valid are each high for exactly one cycle per event. They are never asserted on back-to-back cycles for the same sample.
- clear_flags=1 clears overrun and timeout. If a set condition occurs on the same edge, set wins.
- Any encoding outside the three states: go to IDLE, discard the sample in flight, set timeout←1.

## Timing
- adc_valid captured at edge k with the FIFO empty:
  - fifo_level=1 after edge k.
  - The pop happens at edge k+1, so pipe_valid (or dac_valid in bypass) is high in cycle k+1..k+2. Minimum latency is 1 cycle.
- The pipeline drops ready one edge after it samples pipe_valid. WAIT_DROP therefore normally lasts 1–2 cycles.
- dac_valid is asserted the cycle after pipe_ready is seen rising in WAIT_DONE.
- Throughput: one sample per (pipeline processing time + 3) cycles. The FIFO absorbs bursts up to fifo_depth.
- fifo_level and busy are registered and update on the same edge as the push, pop or state change.
- Reset asserted mid-sample: immediate return to the reset state. The in-flight sample and the FIFO contents are lost. No dac_valid is emitted.

## Test plan
- Reset values: hold reset_n=0 with random inputs, then release. Check all outputs are 0, state is IDLE, fifo_level=0.
- Normal path, enable=1:
  - Stimulus: push 0x1234; model the pipeline as ready dropping 1 cycle after pipe_valid, staying low 10 cycles, then rising with pipe_out_sample=0x0ABC.
  - Required: exactly one pipe_valid with pipe_sample=0x1234; then exactly one dac_valid with dac_sample=0x0ABC; busy low afterwards.
- Burst and overrun, fifo_depth=4:
  - Stimulus: hold pipe_ready=0 and push 6 samples 1..6 on consecutive cycles.
  - Required: fifo_level=4, overrun=1. After releasing pipe_ready, samples 1..4 are dispatched in order and 5, 6 are never seen.
  - Then pulse clear_flags: overrun=0.
- Full plus simultaneous pop: with FIFO full and the pop condition true, push on the same edge. Required: no overrun; the new sample is queued last.
- Bypass: enable=0, push −5 (0xFFFB). Required: dac_valid with dac_sample=0xFFFB one cycle after the FIFO write, and pipe_valid never asserted.
- Timeout, timeout_cycles=16: dispatch 0x0042 while pipe_ready stays 1 forever. Required: timeout=1, dac_sample=0x0042 with dac_valid 16 cycles after dispatch, then return to IDLE.
